cavlc_totalzeros_seq: RTL and testbench
=======================================

# cavlc_totalzeros_seq

Sequential, parametrised total_zeros stage for the CAVLC encoder. It accepts one zig-zag-ordered coefficient block over a valid/ready handshake and scans it one coefficient per cycle. It counts zeros below the highest-frequency nonzero coefficient, cross-checks the count against the supplied TotalCoeff, and emits the H.264 total_zeros VLC. It handles 4x4 luma (16 coefficients), AC (15 coefficients, index 0 excluded) and chroma-DC 2x2 (4 coefficients). It sits between the coeff_token stage and the run_before stage.

## Interface
- COEFF_W, 15, signed coefficient width; nonzero means any bit set.
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  block available
- in_ready  out  1  block accepted when in_valid & in_ready
- mode  in  2  00 = 4x4 (maxNumCoeff 16), 01 = AC (15, indices 1..15), 10 = chroma DC (4, indices 0..3), 11 = reserved
- totalcoeff  in  5  TotalCoeff from coeff_token stage, 0..16
- coeff  in  16*COEFF_W  zig-zag coefficients; index i at bits [i*COEFF_W +: COEFF_W]
- out_valid  out  1  result valid, held until out_ready
- out_ready  in  1  downstream accepts
- totalzero  out  4  zeros below rightmost nonzero, counted within the active index range
- rightmost_idx  out  4  zig-zag index of the highest nonzero coefficient; 0 if none
- code_len  out  4  VLC length 0..9; 0 means nothing to emit
- code_bit  out  9  VLC, right-aligned, MSB emitted first
- err  out  1  mismatch or illegal input

## Operation
- FSM states: IDLE, SCAN, LOOKUP, DONE.
  - IDLE: in_ready = 1. On handshake, register coeff, mode and totalcoeff. Clear counters and set the scan index to the top of the active range: 15 for 4x4 and AC, 3 for chroma DC. Go to SCAN.
  - SCAN: test one index per cycle, descending.
    - Before the first nonzero: skip, and latch rightmost_idx when the first nonzero is found.
    - After it: each zero increments the zero count; each nonzero (including the first) increments nz_cnt.
    - Leave SCAN after the bottom index is processed: 0 for 4x4 and chroma DC, 1 for AC. Go to LOOKUP.
  - LOOKUP: register all outputs, assert out_valid, go to DONE.
  - DONE: hold outputs. When out_valid & out_ready, deassert out_valid, go to IDLE.
- err = 1 in any of these cases:
  - mode == 11;
  - totalcoeff > maxNumCoeff;
  - nz_cnt != totalcoeff.
  When err = 1, code_len = 0 and code_bit = 0. totalzero and rightmost_idx still report scan results.
- No code is emitted (code_len = 0, code_bit = 0, err = 0) when totalcoeff == 0 with all coefficients zero, or totalcoeff == maxNumCoeff.
- Code tables:
  - 4x4 and AC modes use H.264 Table 9-7/9-8, indexed by tzVlcIndex = totalcoeff.
  - Chroma DC uses Table 9-9a.
  - Table lookup is combinational into the LOOKUP register stage.
- In AC mode, coeff index 0 is ignored entirely, including for the nonzero test.

## Timing
- Reset values: in_ready = 0 while rst is high, then 1 in IDLE; out_valid = 0; totalzero = 0; rightmost_idx = 0; code_len = 0; code_bit = 0; err = 0; FSM = IDLE.
- Latency: accept edge E0, then N SCAN edges (N = 16 / 15 / 4). LOOKUP takes edge E(N+1), so out_valid is high after E(N+1). Totals: 17 cycles for 4x4, 16 for AC, 5 for chroma DC.
- One block in flight; in_ready = 0 from the accept edge until the cycle after the output handshake edge.
- Inputs are sampled only at the accept edge; later changes are ignored.
- If out_ready is already high when out_valid rises, the handshake completes on the next edge.
- rst asserted mid-scan or in DONE clears all state and outputs immediately; the block is discarded.

## Test plan
- 4x4 mode, totalcoeff=9, coeff = 3 0 61 20 0 8 0 56 0 0 52 1 50 46 0 0 -> after 17 cycles: totalzero=5, rightmost_idx=13, code_bit=001, code_len=3, err=0.
- 4x4 mode, totalcoeff=6, coeff = 0 0 8 0 61 0 56 0 20 0 1 46 0 0 0 0 -> totalzero=6, rightmost_idx=11, code_bit=011, code_len=3; hold out_ready=0 for 5 cycles and check outputs and out_valid stay stable.
- 4x4 mode, totalcoeff=1, only coeff[15]=-2 -> totalzero=15, code_bit=000000001, code_len=9. Then totalcoeff=16, all coefficients nonzero -> code_len=0, err=0.
- Chroma DC, totalcoeff=1, coeff = 0 0 7 0 -> totalzero=2, rightmost_idx=2, code_bit=001, code_len=3, latency 5 cycles. AC mode with coeff[0]=9 and only coeff[15]=4, totalcoeff=1 -> totalzero=14, rightmost_idx=15, code_bit=000000010, code_len=9.
- Error cases:
  - totalcoeff=5 with 4 nonzeros -> err=1, code_len=0.
  - mode=11 -> err=1.
  - totalcoeff=5 in chroma DC -> err=1.
- Assert rst during SCAN cycle 8 -> out_valid=0 and all outputs 0 immediately. After release, a new block is accepted and its result is correct.

Source files
------------

// File: rtl/cavlc_totalzeros_seq.sv
`default_nettype none
// ============================================================================
// cavlc_totalzeros_seq : one-coefficient-per-cycle total_zeros scan + H.264 VLC
// Revision 1.0
// ============================================================================
module cavlc_totalzeros_seq #(
  parameter int COEFF_W = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  input  logic [1:0]            i_mode,
  input  logic [4:0]            i_totalcoeff,
  input  logic [16*COEFF_W-1:0] i_coeff,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [3:0]            o_totalzero,
  output logic [3:0]            o_rightmost_idx,
  output logic [3:0]            o_code_len,
  output logic [8:0]            o_code_bit,
  output logic                  o_err
);

  localparam logic [1:0] c_MODE_4X4 = 2'd0;
  localparam logic [1:0] c_MODE_AC  = 2'd1;
  localparam logic [1:0] c_MODE_DC  = 2'd2;
  localparam logic [1:0] c_MODE_RSV = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_LOOKUP, S_DONE} state_t;

  state_t                r_state;
  logic [16*COEFF_W-1:0] r_coeff;
  logic [1:0]            r_mode;
  logic [4:0]            r_tc;
  logic [3:0]            r_idx;
  logic                  r_found;
  logic [3:0]            r_zeros;
  logic [4:0]            r_nz;
  logic [3:0]            r_right;
  logic                  r_out_valid;
  logic [3:0]            r_totalzero;
  logic [3:0]            r_rightmost_idx;
  logic [3:0]            r_code_len;
  logic [8:0]            r_code_bit;
  logic                  r_err;

  logic [COEFF_W-1:0]    w_cur;
  logic                  w_cur_nz;
  logic [3:0]            w_bottom;
  logic [4:0]            w_max;
  logic                  w_err;
  logic                  w_emit;
  logic [12:0]           w_vlc;

  // Tables 9-7/9-8, returned as {length, right-aligned code}
  function automatic logic [12:0] f_vlc_4x4(input logic [3:0] tc, input logic [3:0] tz);
    logic [12:0] v;
    v = 13'd0;
    case ({tc, tz})
      8'h10: v = {4'd1, 9'd1}; 8'h11: v = {4'd3, 9'd3}; 8'h12: v = {4'd3, 9'd2}; 8'h13: v = {4'd4, 9'd3};
      8'h14: v = {4'd4, 9'd2}; 8'h15: v = {4'd5, 9'd3}; 8'h16: v = {4'd5, 9'd2}; 8'h17: v = {4'd6, 9'd3};
      8'h18: v = {4'd6, 9'd2}; 8'h19: v = {4'd7, 9'd3}; 8'h1A: v = {4'd7, 9'd2}; 8'h1B: v = {4'd8, 9'd3};
      8'h1C: v = {4'd8, 9'd2}; 8'h1D: v = {4'd9, 9'd3}; 8'h1E: v = {4'd9, 9'd2}; 8'h1F: v = {4'd9, 9'd1};
      8'h20: v = {4'd3, 9'd7}; 8'h21: v = {4'd3, 9'd6}; 8'h22: v = {4'd3, 9'd5}; 8'h23: v = {4'd3, 9'd4};
      8'h24: v = {4'd3, 9'd3}; 8'h25: v = {4'd4, 9'd5}; 8'h26: v = {4'd4, 9'd4}; 8'h27: v = {4'd4, 9'd3};
      8'h28: v = {4'd4, 9'd2}; 8'h29: v = {4'd5, 9'd3}; 8'h2A: v = {4'd5, 9'd2}; 8'h2B: v = {4'd6, 9'd3};
      8'h2C: v = {4'd6, 9'd2}; 8'h2D: v = {4'd6, 9'd1}; 8'h2E: v = {4'd6, 9'd0};
      8'h30: v = {4'd4, 9'd5}; 8'h31: v = {4'd3, 9'd7}; 8'h32: v = {4'd3, 9'd6}; 8'h33: v = {4'd3, 9'd5};
      8'h34: v = {4'd4, 9'd4}; 8'h35: v = {4'd4, 9'd3}; 8'h36: v = {4'd3, 9'd4}; 8'h37: v = {4'd3, 9'd3};
      8'h38: v = {4'd4, 9'd2}; 8'h39: v = {4'd5, 9'd3}; 8'h3A: v = {4'd5, 9'd2}; 8'h3B: v = {4'd6, 9'd1};
      8'h3C: v = {4'd5, 9'd1}; 8'h3D: v = {4'd6, 9'd0};
      8'h40: v = {4'd5, 9'd3}; 8'h41: v = {4'd3, 9'd7}; 8'h42: v = {4'd4, 9'd5}; 8'h43: v = {4'd4, 9'd4};
      8'h44: v = {4'd3, 9'd6}; 8'h45: v = {4'd3, 9'd5}; 8'h46: v = {4'd3, 9'd4}; 8'h47: v = {4'd4, 9'd3};
      8'h48: v = {4'd3, 9'd3}; 8'h49: v = {4'd4, 9'd2}; 8'h4A: v = {4'd5, 9'd2}; 8'h4B: v = {4'd5, 9'd1};
      8'h4C: v = {4'd5, 9'd0};
      8'h50: v = {4'd4, 9'd5}; 8'h51: v = {4'd4, 9'd4}; 8'h52: v = {4'd4, 9'd3}; 8'h53: v = {4'd3, 9'd7};
      8'h54: v = {4'd3, 9'd6}; 8'h55: v = {4'd3, 9'd5}; 8'h56: v = {4'd3, 9'd4}; 8'h57: v = {4'd3, 9'd3};
      8'h58: v = {4'd4, 9'd2}; 8'h59: v = {4'd5, 9'd1}; 8'h5A: v = {4'd4, 9'd1}; 8'h5B: v = {4'd5, 9'd0};
      8'h60: v = {4'd6, 9'd1}; 8'h61: v = {4'd5, 9'd1}; 8'h62: v = {4'd3, 9'd7}; 8'h63: v = {4'd3, 9'd6};
      8'h64: v = {4'd3, 9'd5}; 8'h65: v = {4'd3, 9'd4}; 8'h66: v = {4'd3, 9'd3}; 8'h67: v = {4'd3, 9'd2};
      8'h68: v = {4'd4, 9'd1}; 8'h69: v = {4'd3, 9'd1}; 8'h6A: v = {4'd6, 9'd0};
      8'h70: v = {4'd6, 9'd1}; 8'h71: v = {4'd5, 9'd1}; 8'h72: v = {4'd3, 9'd5}; 8'h73: v = {4'd3, 9'd4};
      8'h74: v = {4'd3, 9'd3}; 8'h75: v = {4'd2, 9'd3}; 8'h76: v = {4'd3, 9'd2}; 8'h77: v = {4'd4, 9'd1};
      8'h78: v = {4'd3, 9'd1}; 8'h79: v = {4'd6, 9'd0};
      8'h80: v = {4'd6, 9'd1}; 8'h81: v = {4'd4, 9'd1}; 8'h82: v = {4'd5, 9'd1}; 8'h83: v = {4'd3, 9'd3};
      8'h84: v = {4'd2, 9'd3}; 8'h85: v = {4'd2, 9'd2}; 8'h86: v = {4'd3, 9'd2}; 8'h87: v = {4'd3, 9'd1};
      8'h88: v = {4'd6, 9'd0};
      8'h90: v = {4'd6, 9'd1}; 8'h91: v = {4'd6, 9'd0}; 8'h92: v = {4'd4, 9'd1}; 8'h93: v = {4'd2, 9'd3};
      8'h94: v = {4'd2, 9'd2}; 8'h95: v = {4'd3, 9'd1}; 8'h96: v = {4'd2, 9'd1}; 8'h97: v = {4'd5, 9'd1};
      8'hA0: v = {4'd5, 9'd1}; 8'hA1: v = {4'd5, 9'd0}; 8'hA2: v = {4'd3, 9'd1}; 8'hA3: v = {4'd2, 9'd3};
      8'hA4: v = {4'd2, 9'd2}; 8'hA5: v = {4'd2, 9'd1}; 8'hA6: v = {4'd4, 9'd1};
      8'hB0: v = {4'd4, 9'd0}; 8'hB1: v = {4'd4, 9'd1}; 8'hB2: v = {4'd3, 9'd1}; 8'hB3: v = {4'd3, 9'd2};
      8'hB4: v = {4'd1, 9'd1}; 8'hB5: v = {4'd3, 9'd3};
      8'hC0: v = {4'd4, 9'd0}; 8'hC1: v = {4'd4, 9'd1}; 8'hC2: v = {4'd2, 9'd1}; 8'hC3: v = {4'd1, 9'd1};
      8'hC4: v = {4'd3, 9'd1};
      8'hD0: v = {4'd3, 9'd0}; 8'hD1: v = {4'd3, 9'd1}; 8'hD2: v = {4'd1, 9'd1}; 8'hD3: v = {4'd2, 9'd1};
      8'hE0: v = {4'd2, 9'd0}; 8'hE1: v = {4'd2, 9'd1}; 8'hE2: v = {4'd1, 9'd1};
      8'hF0: v = {4'd1, 9'd0}; 8'hF1: v = {4'd1, 9'd1};
      default: v = 13'd0;
    endcase
    return v;
  endfunction

  // Table 9-9a (chroma DC 2x2)
  function automatic logic [12:0] f_vlc_dc(input logic [1:0] tc, input logic [1:0] tz);
    logic [12:0] v;
    v = 13'd0;
    case ({tc, tz})
      4'h4: v = {4'd1, 9'd1}; 4'h5: v = {4'd2, 9'd1}; 4'h6: v = {4'd3, 9'd1}; 4'h7: v = {4'd3, 9'd0};
      4'h8: v = {4'd1, 9'd1}; 4'h9: v = {4'd2, 9'd1}; 4'hA: v = {4'd2, 9'd0};
      4'hC: v = {4'd1, 9'd1}; 4'hD: v = {4'd1, 9'd0};
      default: v = 13'd0;
    endcase
    return v;
  endfunction

  assign w_cur    = r_coeff[r_idx*COEFF_W +: COEFF_W];
  assign w_cur_nz = |w_cur;
  assign w_bottom = (r_mode == c_MODE_AC) ? 4'd1 : 4'd0;

  always_comb begin
    case (r_mode)
      c_MODE_4X4: w_max = 5'd16;
      c_MODE_AC:  w_max = 5'd15;
      c_MODE_DC:  w_max = 5'd4;
      default:    w_max = 5'd16;
    endcase
  end

  assign w_err  = (r_mode == c_MODE_RSV) || (r_tc > w_max) || (r_nz != r_tc);
  assign w_emit = !w_err && (r_tc != 5'd0) && (r_tc != w_max);

  always_comb begin
    w_vlc = 13'd0;
    if (w_emit) begin
      if (r_mode == c_MODE_DC) w_vlc = f_vlc_dc(r_tc[1:0], r_zeros[1:0]);
      else                     w_vlc = f_vlc_4x4(r_tc[3:0], r_zeros);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_coeff         <= '0;
      r_mode          <= 2'd0;
      r_tc            <= 5'd0;
      r_idx           <= 4'd0;
      r_found         <= 1'b0;
      r_zeros         <= 4'd0;
      r_nz            <= 5'd0;
      r_right         <= 4'd0;
      r_out_valid     <= 1'b0;
      r_totalzero     <= 4'd0;
      r_rightmost_idx <= 4'd0;
      r_code_len      <= 4'd0;
      r_code_bit      <= 9'd0;
      r_err           <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_in_valid) begin
            r_coeff <= i_coeff;
            r_mode  <= i_mode;
            r_tc    <= i_totalcoeff;
            r_idx   <= (i_mode == c_MODE_DC) ? 4'd3 : 4'd15;
            r_found <= 1'b0;
            r_zeros <= 4'd0;
            r_nz    <= 5'd0;
            r_right <= 4'd0;
            r_state <= S_SCAN;
          end
        end
        S_SCAN: begin
          // Zeros only count once the highest nonzero has been passed
          if (w_cur_nz) begin
            if (!r_found) begin
              r_found <= 1'b1;
              r_right <= r_idx;
            end
            r_nz <= r_nz + 5'd1;
          end else if (r_found) begin
            r_zeros <= r_zeros + 4'd1;
          end
          if (r_idx == w_bottom) r_state <= S_LOOKUP;
          else                   r_idx   <= r_idx - 4'd1;
        end
        S_LOOKUP: begin
          r_totalzero     <= r_zeros;
          r_rightmost_idx <= r_right;
          r_code_len      <= w_vlc[12:9];
          r_code_bit      <= w_vlc[8:0];
          r_err           <= w_err;
          r_out_valid     <= 1'b1;
          r_state         <= S_DONE;
        end
        S_DONE: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_in_ready      = (r_state == S_IDLE) && !rst;
  assign o_out_valid     = r_out_valid;
  assign o_totalzero     = r_totalzero;
  assign o_rightmost_idx = r_rightmost_idx;
  assign o_code_len      = r_code_len;
  assign o_code_bit      = r_code_bit;
  assign o_err           = r_err;

endmodule
`default_nettype wire

// File: tb/tb_cavlc_totalzeros_seq.sv
`default_nettype none
// ============================================================================
// tb_cavlc_totalzeros_seq : randomized + directed bench with a string-table model
// Revision 1.0
// ============================================================================
module tb_cavlc_totalzeros_seq;
  localparam int CW = 15;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            i_in_valid = 1'b0;
  logic            o_in_ready;
  logic [1:0]      i_mode = 2'd0;
  logic [4:0]      i_totalcoeff = 5'd0;
  logic [16*CW-1:0] coeff_bus;
  logic            o_out_valid;
  logic            i_out_ready = 1'b0;
  logic [3:0]      o_totalzero;
  logic [3:0]      o_rightmost_idx;
  logic [3:0]      o_code_len;
  logic [8:0]      o_code_bit;
  logic            o_err;

  logic [CW-1:0]   cf [16];
  int              dv [16];
  int              total = 0;
  int              bad = 0;

  cavlc_totalzeros_seq #(.COEFF_W(CW)) dut (
    .clk(clk), .rst(rst),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
    .i_mode(i_mode), .i_totalcoeff(i_totalcoeff), .i_coeff(coeff_bus),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
    .o_totalzero(o_totalzero), .o_rightmost_idx(o_rightmost_idx),
    .o_code_len(o_code_len), .o_code_bit(o_code_bit), .o_err(o_err)
  );

  always #5 clk = ~clk;

  always_comb begin
    coeff_bus = '0;
    for (int i = 0; i < 16; i++) coeff_bus[i*CW +: CW] = cf[i];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Codeword strings per tzVlcIndex, listed for total_zeros = 0, 1, 2, ...
  function automatic string tz_row(input int dc, input int tc);
    if (dc != 0) begin
      case (tc)
        1: return "1 01 001 000";
        2: return "1 01 00";
        3: return "1 0";
        default: return "";
      endcase
    end
    case (tc)
      1:  return "1 011 010 0011 0010 00011 00010 000011 000010 0000011 0000010 00000011 00000010 000000011 000000010 000000001";
      2:  return "111 110 101 100 011 0101 0100 0011 0010 00011 00010 000011 000010 000001 000000";
      3:  return "0101 111 110 101 0100 0011 100 011 0010 00011 00010 000001 00001 000000";
      4:  return "00011 111 0101 0100 110 101 100 0011 011 0010 00010 00001 00000";
      5:  return "0101 0100 0011 111 110 101 100 011 0010 00001 0001 00000";
      6:  return "000001 00001 111 110 101 100 011 010 0001 001 000000";
      7:  return "000001 00001 101 100 011 11 010 0001 001 000000";
      8:  return "000001 0001 00001 011 11 10 010 001 000000";
      9:  return "000001 000000 0001 11 10 001 01 00001";
      10: return "00001 00000 001 11 10 01 0001";
      11: return "0000 0001 001 010 1 011";
      12: return "0000 0001 01 1 001";
      13: return "000 001 1 01";
      14: return "00 01 1";
      15: return "0 1";
      default: return "";
    endcase
  endfunction

  function automatic void vlc_lookup(input int dc, input int tc, input int tz, output int len, output int code);
    string s;
    int    k;
    byte   ch;
    s = tz_row(dc, tc);
    k = 0; len = 0; code = 0;
    for (int i = 0; i < s.len(); i++) begin
      ch = s.getc(i);
      if (ch == " ") k++;
      else if (k == tz) begin
        len++;
        code = code * 2 + ((ch == "1") ? 1 : 0);
      end
    end
  endfunction

  function automatic void model(input int mode, input int tc, output int tz, output int rm,
                                output int len, output int code, output int err);
    int lo, hi, mx, nz, top;
    lo = (mode == 1) ? 1 : 0;
    hi = (mode == 2) ? 3 : 15;
    mx = (mode == 1) ? 15 : (mode == 2) ? 4 : 16;
    nz = 0; top = -1;
    for (int i = lo; i <= hi; i++) if (cf[i] != 0) begin nz++; top = i; end
    tz = 0;
    for (int i = lo; i <= top; i++) if (cf[i] == 0) tz++;
    rm  = (top < 0) ? 0 : top;
    err = (mode == 3 || tc > mx || nz != tc) ? 1 : 0;
    len = 0; code = 0;
    if (err == 0 && tc != 0 && tc != mx) vlc_lookup((mode == 2) ? 1 : 0, tc, tz, len, code);
  endfunction

  function automatic logic [CW-1:0] nzval();
    int r;
    r = $urandom_range(1, (1 << CW) - 1);
    return r[CW-1:0];
  endfunction

  task automatic load_dv();
    for (int i = 0; i < 16; i++) cf[i] = dv[i][CW-1:0];
  endtask

  task automatic check_out(input string tag, input int mode, input int tz, input int rm,
                           input int len, input int code, input int err);
    check_eq({tag, "/valid"}, o_out_valid, 1);
    if (mode != 3) begin
      check_eq({tag, "/totalzero"}, o_totalzero, tz);
      check_eq({tag, "/rightmost"}, o_rightmost_idx, rm);
    end
    check_eq({tag, "/code_len"}, o_code_len, len);
    check_eq({tag, "/code_bit"}, o_code_bit, code);
    check_eq({tag, "/err"}, o_err, err);
  endtask

  task automatic run_block(input string tag, input int mode, input int tc, input int hold);
    int e_tz, e_rm, e_len, e_code, e_err, n, lat;
    model(mode, tc, e_tz, e_rm, e_len, e_code, e_err);
    n = 0;
    while (!o_in_ready && n < 50) begin @(posedge clk); #1; n++; end
    check_eq({tag, "/ready"}, o_in_ready, 1);
    i_mode = mode[1:0];
    i_totalcoeff = tc[4:0];
    i_in_valid = 1'b1;
    i_out_ready = (hold == 0);
    @(posedge clk); #1;
    i_in_valid = 1'b0;
    n = $urandom;
    i_mode = n[1:0];
    i_totalcoeff = n[6:2];
    for (int i = 0; i < 16; i++) cf[i] = nzval();
    check_eq({tag, "/busy"}, o_in_ready, 0);
    lat = 0;
    while (!o_out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    if (!o_out_valid) begin
      check_eq({tag, "/timeout"}, o_out_valid, 1);
      return;
    end
    if (mode != 3) check_eq({tag, "/latency"}, lat, (mode == 1) ? 16 : (mode == 2) ? 5 : 17);
    check_out(tag, mode, e_tz, e_rm, e_len, e_code, e_err);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check_out({tag, "/hold"}, mode, e_tz, e_rm, e_len, e_code, e_err);
    end
    i_out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq({tag, "/valid_drop"}, o_out_valid, 0);
    check_eq({tag, "/ready_back"}, o_in_ready, 1);
    i_out_ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) cf[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst/in_ready", o_in_ready, 0);
    check_eq("rst/out_valid", o_out_valid, 0);
    check_eq("rst/totalzero", o_totalzero, 0);
    check_eq("rst/rightmost", o_rightmost_idx, 0);
    check_eq("rst/code_len", o_code_len, 0);
    check_eq("rst/code_bit", o_code_bit, 0);
    check_eq("rst/err", o_err, 0);
    rst = 1'b0;
    #1;
    check_eq("rst/in_ready_release", o_in_ready, 1);

    dv = '{3, 0, 61, 20, 0, 8, 0, 56, 0, 0, 52, 1, 50, 46, 0, 0};
    load_dv(); run_block("v_tc9", 0, 9, 1);
    dv = '{0, 0, 8, 0, 61, 0, 56, 0, 20, 0, 1, 46, 0, 0, 0, 0};
    load_dv(); run_block("v_tc6_hold", 0, 6, 5);
    dv = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, -2};
    load_dv(); run_block("v_tz15", 0, 1, 0);
    dv = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16};
    load_dv(); run_block("v_full", 0, 16, 0);
    dv = '{0, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    load_dv(); run_block("v_dc", 2, 1, 1);
    dv = '{9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4};
    load_dv(); run_block("v_ac", 1, 1, 0);

    // Reset in the middle of a scan, with the previous result still on the outputs
    dv = '{0, 0, 8, 0, 61, 0, 56, 0, 20, 0, 1, 46, 0, 0, 0, 0};
    load_dv();
    i_mode = 2'd0; i_totalcoeff = 5'd6; i_in_valid = 1'b1;
    @(posedge clk); #1;
    i_in_valid = 1'b0;
    repeat (8) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    check_eq("mid_rst/out_valid", o_out_valid, 0);
    check_eq("mid_rst/totalzero", o_totalzero, 0);
    check_eq("mid_rst/rightmost", o_rightmost_idx, 0);
    check_eq("mid_rst/code_len", o_code_len, 0);
    check_eq("mid_rst/code_bit", o_code_bit, 0);
    check_eq("mid_rst/err", o_err, 0);
    check_eq("mid_rst/in_ready", o_in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    dv = '{3, 0, 61, 20, 0, 8, 0, 56, 0, 0, 52, 1, 50, 46, 0, 0};
    load_dv(); run_block("v_after_rst", 0, 9, 0);

    dv = '{5, 0, 3, 0, 0, 2, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    load_dv(); run_block("e_count", 0, 5, 0);
    dv = '{3, 0, 61, 20, 0, 8, 0, 56, 0, 0, 52, 1, 50, 46, 0, 0};
    load_dv(); run_block("e_mode", 3, 9, 0);
    dv = '{1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    load_dv(); run_block("e_dc_tc", 2, 5, 0);

    for (int t = 0; t < 150; t++) begin
      int r, mode, lo, hi, k, tc, p;
      r = $urandom_range(0, 9);
      mode = (r < 4) ? 0 : (r < 7) ? 1 : (r < 9) ? 2 : 3;
      lo = (mode == 1) ? 1 : 0;
      hi = (mode == 2) ? 3 : 15;
      for (int i = 0; i < 16; i++) cf[i] = '0;
      k = $urandom_range(0, hi - lo + 1);
      for (int j = 0; j < k; j++) begin
        do p = $urandom_range(lo, hi); while (cf[p] != 0);
        cf[p] = nzval();
      end
      if (mode == 1 && $urandom_range(0, 1) == 1) cf[0] = nzval();
      if (mode == 2) for (int i = 4; i < 16; i++) if ($urandom_range(0, 3) == 0) cf[i] = nzval();
      tc = k;
      if ($urandom_range(0, 7) == 0) tc = $urandom_range(0, 16);
      run_block("rnd", mode, tc, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
